// File: rtl/cpu_pkg.sv
// Shared CPU constants and the operand-stack command decode.
package cpu_pkg;

   localparam int WORD_W      = 8;
   localparam int STACK_DEPTH = 8;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_TOS,
      OP_REPL
   } stack_op_e;

   // push&pop replaces the top; tos only counts when alone
   function automatic stack_op_e decode_op(
      input logic push,
      input logic pop,
      input logic tos
   );
      stack_op_e op;
      op = OP_NONE;
      unique case (1'b1)
         push & pop:          op = OP_REPL;
         push & ~pop:         op = OP_PUSH;
         pop & ~push:         op = OP_POP;
         tos & ~push & ~pop:  op = OP_TOS;
         default:             op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Command/result bundle between the multicycle controller,
// the data path and the operand stack.
interface stack_unit_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             push;
   logic             pop;
   logic             tos;
   logic             clr_err;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             err_ovf;
   logic             err_unf;

   modport master (
      output push, pop, tos, din, clr_err,
      input  dout, count, empty, full, err_ovf, err_unf
   );

   modport slave (
      input  push, pop, tos, din, clr_err,
      output dout, count, empty, full, err_ovf, err_unf
   );

endinterface

// File: rtl/stack_unit_regfile.sv
// Stack storage: one synchronous write port, one
// asynchronous read port, contents not reset.
module stack_regfile #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO operand stack: pointer, command decode, registered
// result word and sticky error flags.
module stack_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int DEPTH = STACK_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   stack_unit_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [CW-1:0]    sp_q, sp_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             empty, full;
   logic [AW-1:0]    top_a;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] rdata;
   stack_op_e        op;

   assign empty = (sp_q == '0);
   assign full  = (sp_q == CW'(DEPTH));
   // low bits of sp-1 stay correct at sp==DEPTH
   assign top_a = sp_q[AW-1:0] - AW'(1);
   assign op    = decode_op(bus.push, bus.pop, bus.tos);

   stack_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_rf (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (bus.din),
      .raddr (top_a),
      .rdata (rdata)
   );

   always_comb begin
      sp_d   = sp_q;
      dout_d = dout_q;
      ovf_d  = ovf_q & ~bus.clr_err;
      unf_d  = unf_q & ~bus.clr_err;
      we     = 1'b0;
      waddr  = sp_q[AW-1:0];
      unique case (op)
         OP_REPL: begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               dout_d = rdata;
               we     = 1'b1;
               waddr  = top_a;
            end
         end
         OP_PUSH: begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               we   = 1'b1;
               sp_d = sp_q + CW'(1);
            end
         end
         OP_POP: begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               dout_d = rdata;
               sp_d   = sp_q - CW'(1);
            end
         end
         OP_TOS: begin
            if (empty) unf_d  = 1'b1;
            else       dout_d = rdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp_q   <= '0;
         dout_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         sp_q   <= sp_d;
         dout_q <= dout_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   assign bus.dout    = dout_q;
   assign bus.count   = sp_q;
   assign bus.empty   = empty;
   assign bus.full    = full;
   assign bus.err_ovf = ovf_q;
   assign bus.err_unf = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed and random stimulus for stack_unit, checked
// against a queue-based LIFO model.
module tb_stack_unit;

   localparam int DEPTH = 8;

   logic clk;
   logic rst;
   int   checks;
   int   passed;

   logic [7:0] mq[$];
   logic [7:0] m_dout;
   logic       m_ovf;
   logic       m_unf;

   stack_unit_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

   stack_unit #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
      check({tag, ".dout"},  32'(bus.dout),  32'(m_dout));
      check({tag, ".empty"}, 32'(bus.empty), 32'(mq.size() == 0));
      check({tag, ".full"},  32'(bus.full),  32'(mq.size() == DEPTH));
      check({tag, ".ovf"},   32'(bus.err_ovf), 32'(m_ovf));
      check({tag, ".unf"},   32'(bus.err_unf), 32'(m_unf));
   endtask

   task automatic model(input logic pu, input logic po,
                        input logic to, input logic [7:0] d,
                        input logic cl);
      if (cl) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (pu && po) begin
         if (mq.size() == 0) m_unf = 1'b1;
         else begin
            m_dout = mq[$];
            mq[$]  = d;
         end
      end else if (pu) begin
         if (mq.size() == DEPTH) m_ovf = 1'b1;
         else mq.push_back(d);
      end else if (po) begin
         if (mq.size() == 0) m_unf = 1'b1;
         else m_dout = mq.pop_back();
      end else if (to) begin
         if (mq.size() == 0) m_unf = 1'b1;
         else m_dout = mq[$];
      end
   endtask

   task automatic step(input string tag, input logic pu,
                       input logic po, input logic to,
                       input logic [7:0] d, input logic cl);
      @(negedge clk);
      bus.push    = pu;
      bus.pop     = po;
      bus.tos     = to;
      bus.din     = d;
      bus.clr_err = cl;
      @(posedge clk);
      #1;
      model(pu, po, to, d, cl);
      check_all(tag);
   endtask

   task automatic model_reset();
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      model_reset();
      bus.push = 0; bus.pop = 0; bus.tos = 0;
      bus.din = '0; bus.clr_err = 0;
      rst = 1'b0;
      #23;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;

      // 1: basic push / tos / pop
      step("p1", 1, 0, 0, 8'h11, 0);
      step("p2", 1, 0, 0, 8'h22, 0);
      step("p3", 1, 0, 0, 8'h33, 0);
      step("tos", 0, 0, 1, 8'h00, 0);
      check("tos_lit", 32'(bus.dout), 32'h33);
      step("pop1", 0, 1, 0, 8'h00, 0);
      step("pop2", 0, 1, 0, 8'h00, 0);
      step("pop3", 0, 1, 0, 8'h00, 0);
      check("pop3_lit", 32'(bus.dout), 32'h11);

      // 2: fill and overflow
      for (int i = 1; i <= 8; i++) step("fill", 1, 0, 0, 8'(i), 0);
      step("ovf", 1, 0, 0, 8'h09, 0);
      check("ovf_lit", 32'(bus.err_ovf), 32'h1);
      step("pop_ovf", 0, 1, 0, 8'h00, 0);
      check("no_09", 32'(bus.dout), 32'h08);
      for (int i = 0; i < 7; i++) step("drain", 0, 1, 0, 8'h00, 0);

      // 3: underflow and clear
      step("unf_pop", 0, 1, 0, 8'h00, 0);
      step("unf_tos", 0, 0, 1, 8'h00, 0);
      step("clr", 0, 0, 0, 8'h00, 1);
      step("clr_set", 0, 1, 0, 8'h00, 1);
      check("set_wins", 32'(bus.err_unf), 32'h1);
      step("clr2", 0, 0, 0, 8'h00, 1);

      // 4: replace
      step("r_p5", 1, 0, 0, 8'h05, 0);
      step("r_pA", 1, 0, 0, 8'h0A, 0);
      step("repl", 1, 1, 0, 8'h7F, 0);
      check("repl_lit", 32'(bus.dout), 32'h0A);
      step("r_pop", 0, 1, 0, 8'h00, 0);
      check("r_pop_lit", 32'(bus.dout), 32'h7F);
      step("r_pop2", 0, 1, 0, 8'h00, 0);
      for (int i = 0; i < 8; i++) step("r_fill", 1, 0, 0, 8'(8'hA0 + i), 0);
      step("repl_full", 1, 1, 0, 8'h5A, 0);
      for (int i = 0; i < 8; i++) step("r_drain", 0, 1, 0, 8'h00, 0);
      step("repl_empty", 1, 1, 0, 8'h77, 0);
      step("clr3", 0, 0, 0, 8'h00, 1);

      // 5: tos loses to push / pop
      step("push_tos", 1, 0, 1, 8'h44, 0);
      step("pop_tos", 0, 1, 1, 8'h00, 0);
      check("pop_tos_lit", 32'(bus.dout), 32'h44);

      // 6: asynchronous reset mid-operation
      step("unf_pre", 0, 1, 0, 8'h00, 0);
      step("a1", 1, 0, 0, 8'hC1, 0);
      step("a2", 1, 0, 0, 8'hC2, 0);
      step("a3", 1, 0, 0, 8'hC3, 0);
      step("a_tos", 0, 0, 1, 8'h00, 0);
      @(negedge clk);
      bus.push = 0; bus.pop = 1; bus.tos = 0;
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      bus.pop = 0;
      rst = 1'b1;
      step("post_push", 1, 0, 0, 8'h66, 0);
      step("post_tos", 0, 0, 1, 8'h00, 0);
      check("post_lit", 32'(bus.dout), 32'h66);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step("rand",
              $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 40,
              $urandom_range(0, 99) < 20,
              8'($urandom),
              $urandom_range(0, 99) < 6);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware LIFO operand stack consumed by the CPU data path; executes the push, pop and tos strobes issued by the multicycle controller.
- Pop/tos results are returned in a registered output word that the data path loads into its A/B operand registers.
- Push data arrives from the data path memory-to-stack mux (memory data or ALU result).
- Adds occupancy status and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of stack entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- push  input  1  push din this cycle
- pop  input  1  pop the top entry into dout
- tos  input  1  copy the top entry into dout without removing it
- din  input  WIDTH  data to push
- clr_err  input  1  synchronous clear of both error flags
- dout  output  WIDTH  registered result of the last successful pop or tos
- count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- err_ovf  output  1  sticky: a push was rejected because the stack was full
- err_unf  output  1  sticky: a pop or tos was rejected because the stack was empty

Behaviour:
- Reset, while rst is low, asynchronous:
  - sp = 0, dout = 0, err_ovf = 0, err_unf = 0; empty = 1, full = 0.
  - Storage array contents are not reset.
  - Reset asserted mid-operation discards any in-flight command.
- count = sp. empty and full are decoded combinationally from sp.
- Commands are sampled at the rising edge. One operation per cycle, chosen by priority:
  1. Replace (push & pop):
     - Non-empty: dout <= mem[sp-1], then mem[sp-1] <= din; sp unchanged. Legal even when full.
     - Empty: err_unf <= 1; nothing is written and sp is unchanged.
  2. Push only:
     - Not full: mem[sp] <= din, sp <= sp+1.
     - Full: err_ovf <= 1; no write, sp unchanged.
  3. Pop only:
     - Non-empty: dout <= mem[sp-1], sp <= sp-1.
     - Empty: err_unf <= 1; dout and sp unchanged.
  4. Tos only, with push and pop low:
     - Non-empty: dout <= mem[sp-1].
     - Empty: err_unf <= 1.
  - tos asserted together with push or pop is ignored.
- Latency:
  - dout is valid on the cycle after the pop/tos/replace edge and holds until the next successful pop, tos or replace.
  - count/empty/full reflect a push or pop on the cycle after the edge.
- Error flags:
  - Set on the erroring edge and stay set until clr_err.
  - If clr_err and a new error occur in the same cycle, set wins.
- No wrap-around: sp saturates by rejection, never modulo.
- Idle cycle (push, pop and tos all low): all state holds.

Decomposition:
- Shared package cpu_pkg:
  - WORD_W = 8 and STACK_DEPTH = 8 constants, reused by the data path.
  - An enum stack_op_e {OP_NONE, OP_PUSH, OP_POP, OP_TOS, OP_REPL}, produced by a priority-decode function also defined in the package.
- Sub-module stack_regfile:
  - DEPTH×WIDTH array, one synchronous write port (we, waddr, wdata), one asynchronous read port (raddr → rdata).
  - No reset.
- stack_unit keeps the pointer, decode, dout register and flags.

Test Plan:
1. Reset with rst=0, then release; push 0x11, 0x22, 0x33 on consecutive cycles → count = 3. Then tos → dout = 0x33, count stays 3. Then pop ×3 → dout = 0x33, 0x22, 0x11 and empty = 1.
2. Push 8 values 0x01..0x08 → full = 1. Push 0x09 → err_ovf = 1, count = 8. Pop → dout = 0x08, proving 0x09 was not written.
3. From empty: pop → err_unf = 1, dout holds its previous value. Tos → err_unf stays 1. clr_err → both flags 0. clr_err together with a new pop on empty → err_unf = 1.
4. Stack holds [0x05, 0x0A] (0x0A on top). push & pop with din = 0x7F → dout = 0x0A, count = 2. Next pop → dout = 0x7F. Replace when full also succeeds with count staying 8. Replace on empty → err_unf = 1 and count = 0.
5. Priority checks:
   - push & tos on empty with din = 0x44 → count = 1, dout unchanged.
   - Then pop & tos → dout = 0x44, count = 0.
6. Push 3 values, then assert rst low asynchronously between clock edges while a pop is requested → count = 0, dout = 0, flags clear immediately. After release, a push of 0x66 then tos → dout = 0x66.
